// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with in-order fetch buffer and IF/ID register
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_EN_IF,
    input  logic        reg_FD_stall,
    input  logic        reg_FD_flush,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        valid_ID,
    output logic [31:0] PC_ID,
    output logic [31:0] inst_ID
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = CW + 4;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      buf_pc_q   [DEPTH];
    logic [31:0]      buf_pc_d   [DEPTH];
    logic [31:0]      buf_data_q [DEPTH];
    logic [31:0]      buf_data_d [DEPTH];
    logic [DEPTH-1:0] buf_filled_q, buf_filled_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [CW-1:0]    count_q, count_d, pend_q, pend_d;
    logic [KW-1:0]    kill_q, kill_d;
    logic             valid_id_q, valid_id_d;
    logic [31:0]      pc_id_q, pc_id_d, inst_id_q, inst_id_d;

    logic             issue, pop, resp_live;
    logic [KW-1:0]    kill_sum;

    assign imem_req_valid = PC_EN_IF & ~reg_FD_flush & (count_q < CW'(DEPTH)) & ~rst;
    assign imem_req_addr  = pc_q;
    assign issue          = imem_req_valid & imem_req_ready;
    assign pop            = ~reg_FD_flush & ~reg_FD_stall & (count_q != '0) & buf_filled_q[head_q];
    // pend_q counts allocated entries still waiting for data; responses owed to killed requests sit in kill_q
    assign resp_live      = imem_resp_valid & (kill_q == '0) & (pend_q != '0);
    assign kill_sum       = kill_q + KW'(pend_q);

    assign valid_ID = valid_id_q;
    assign PC_ID    = pc_id_q;
    assign inst_ID  = inst_id_q;

    always_comb begin
        pc_d         = pc_q;
        buf_pc_d     = buf_pc_q;
        buf_data_d   = buf_data_q;
        buf_filled_d = buf_filled_q;
        head_d       = head_q;
        tail_d       = tail_q;
        fill_d       = fill_q;
        count_d      = count_q;
        pend_d       = pend_q;
        kill_d       = kill_q;
        valid_id_d   = valid_id_q;
        pc_id_d      = pc_id_q;
        inst_id_d    = inst_id_q;

        if (reg_FD_flush) begin
            pc_d         = branch_target;
            buf_filled_d = '0;
            head_d       = '0;
            tail_d       = '0;
            fill_d       = '0;
            count_d      = '0;
            pend_d       = '0;
            // a response landing this cycle retires one owed response, live or already killed
            kill_d       = (imem_resp_valid && (kill_sum != '0)) ? kill_sum - KW'(1) : kill_sum;
            valid_id_d   = 1'b0;
            inst_id_d    = NOP_INST;
        end else begin
            if (issue) begin
                buf_pc_d[tail_q]     = pc_q;
                buf_filled_d[tail_q] = 1'b0;
                tail_d               = tail_q + PW'(1);
                pc_d                 = pc_q + 32'd4;
            end

            if (imem_resp_valid && (kill_q != '0)) begin
                kill_d = kill_q - KW'(1);
            end else if (resp_live) begin
                buf_data_d[fill_q]   = imem_resp_data;
                buf_filled_d[fill_q] = 1'b1;
                fill_d               = fill_q + PW'(1);
            end

            if (pop) begin
                valid_id_d           = 1'b1;
                pc_id_d              = buf_pc_q[head_q];
                inst_id_d            = buf_data_q[head_q];
                buf_filled_d[head_q] = 1'b0;
                head_d               = head_q + PW'(1);
            end else if (!reg_FD_stall) begin
                valid_id_d = 1'b0;
                inst_id_d  = NOP_INST;
            end

            count_d = count_q + CW'(issue) - CW'(pop);
            pend_d  = pend_q + CW'(issue) - CW'(resp_live);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_q[i]   <= '0;
                buf_data_q[i] <= '0;
            end
            buf_filled_q <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            fill_q       <= '0;
            count_q      <= '0;
            pend_q       <= '0;
            kill_q       <= '0;
            valid_id_q   <= 1'b0;
            pc_id_q      <= '0;
            inst_id_q    <= NOP_INST;
        end else begin
            pc_q         <= pc_d;
            buf_pc_q     <= buf_pc_d;
            buf_data_q   <= buf_data_d;
            buf_filled_q <= buf_filled_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            fill_q       <= fill_d;
            count_q      <= count_d;
            pend_q       <= pend_d;
            kill_q       <= kill_d;
            valid_id_q   <= valid_id_d;
            pc_id_q      <= pc_id_d;
            inst_id_q    <= inst_id_d;
        end
    end
endmodule
